// File: rtl/ddr3_app_seq_if.sv
// rtl/ddr3_app_seq_if.sv - MIG 7-series app interface bundle between sequencer (master) and MIG (slave)
interface ddr3_app_seq_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr3_app_seq.sv
// rtl/ddr3_app_seq.sv - start-triggered DDR3 burst sequencer on the MIG app interface
// Optional stall counter: define DDR3_APP_SEQ_STALL_CNT_EN.
module ddr3_app_seq #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int MASK_W     = 32,
  parameter int ADDR_STEP  = 8,
  parameter int CNT_W      = 16,
  parameter int RBUF_DEPTH = 8
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              init_calib_complete,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  ddr3_app_seq_if.master    app,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cnt
);

  localparam int PTR_W = $clog2(RBUF_DEPTH);
  localparam int CRD_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cmd_q;
  logic              en_q;
  logic              wren_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              pend_q;
  logic              cmd_ok_q;
  logic              dat_ok_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  returned_q;
  logic [CRD_W-1:0]  credit_q;
  logic [CRD_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [DATA_W-1:0] mem [RBUF_DEPTH];

  logic cmd_acc, dat_acc, cmd_done, dat_done;
  logic wr_fire, push, pop, start_ok, rd_raise;

  assign cmd_acc  = en_q && app.app_rdy;
  assign dat_acc  = wren_q && app.app_wdf_rdy;
  assign cmd_done = cmd_ok_q || cmd_acc;
  assign dat_done = dat_ok_q || dat_acc;

  assign wr_ready = (state_q == S_WR) && !pend_q && (remaining_q != '0);
  assign wr_fire  = wr_valid && wr_ready;
  assign start_ok = (state_q == S_IDLE) && init_calib_complete && (start_wr || start_rd);

  // Returns only land while a read burst is live; anything arriving after an abort is dropped.
  assign push     = (state_q == S_RD) && app.app_rd_data_valid;
  assign rd_valid = (fifo_cnt_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rptr_q];

  // A credit covers a read from command raise until its data lands in the FIFO.
  assign rd_raise = (state_q == S_RD) && !en_q && (issued_q < num_q) &&
                    (({1'b0, credit_q} + {1'b0, fifo_cnt_q}) < (CRD_W + 1)'(RBUF_DEPTH));

  assign app.app_addr     = addr_q;
  assign app.app_cmd      = cmd_q;
  assign app.app_en       = en_q;
  assign app.app_wdf_data = wdata_q;
  assign app.app_wdf_wren = wren_q;
  assign app.app_wdf_end  = wren_q;
  assign app.app_wdf_mask = {MASK_W{1'b0}};
  assign busy             = busy_q;
  assign done             = done_q;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmd_q       <= 3'b000;
      en_q        <= 1'b0;
      wren_q      <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      cmd_ok_q    <= 1'b0;
      dat_ok_q    <= 1'b0;
      num_q       <= '0;
      remaining_q <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      credit_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            addr_q      <= base_addr;
            num_q       <= num_words;
            remaining_q <= num_words;
            issued_q    <= '0;
            returned_q  <= '0;
            credit_q    <= '0;
            cmd_q       <= start_wr ? 3'b000 : 3'b001;
            busy_q      <= 1'b1;
            if (num_words == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (start_wr) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_WR: begin
          if (cmd_acc) en_q <= 1'b0;
          if (dat_acc) wren_q <= 1'b0;
          // Command and data channels complete independently; the word retires when both have.
          if (pend_q) begin
            if (cmd_done && dat_done) begin
              pend_q      <= 1'b0;
              cmd_ok_q    <= 1'b0;
              dat_ok_q    <= 1'b0;
              addr_q      <= addr_q + ADDR_W'(ADDR_STEP);
              remaining_q <= remaining_q - CNT_W'(1);
            end else begin
              cmd_ok_q <= cmd_done;
              dat_ok_q <= dat_done;
            end
          end else if (wr_fire) begin
            wdata_q <= wr_data;
            en_q    <= 1'b1;
            wren_q  <= 1'b1;
            cmd_q   <= 3'b000;
            pend_q  <= 1'b1;
          end else if (remaining_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_RD: begin
          if (cmd_acc) begin
            en_q     <= 1'b0;
            addr_q   <= addr_q + ADDR_W'(ADDR_STEP);
            issued_q <= issued_q + CNT_W'(1);
          end else if (rd_raise) begin
            en_q <= 1'b1;
          end
          credit_q   <= credit_q + CRD_W'(rd_raise) - CRD_W'(push);
          returned_q <= returned_q + CNT_W'(push);
          if ((returned_q == num_q) && (fifo_cnt_q == '0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      fifo_cnt_q <= fifo_cnt_q + CRD_W'(push) - CRD_W'(pop);
    end
  end

  always_ff @(posedge ui_clk) begin
    if (push) mem[wptr_q] <= app.app_rd_data;
  end

`ifdef DDR3_APP_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (en_q && !app.app_rdy && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ddr3_app_seq.sv
// tb/tb_ddr3_app_seq.sv - scoreboard bench for ddr3_app_seq with a behavioural MIG and stream source/sink
module tb_ddr3_app_seq;
  localparam int ADDR_W = 29, DATA_W = 256, MASK_W = 32, CNT_W = 16;

  logic              ui_clk = 1'b0;
  logic              ui_clk_sync_rst = 1'b1;
  logic              init_calib_complete = 1'b0;
  logic              start_wr = 1'b0, start_rd = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_words = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              busy, done;
  logic [31:0]       stall_cnt;

  ddr3_app_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) app_bus ();

  ddr3_app_seq dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete),
    .start_wr(start_wr), .start_rd(start_rd), .base_addr(base_addr), .num_words(num_words),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .app(app_bus), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0, errors = 0;
  logic [ADDR_W-1:0] exp_waddr[$], exp_raddr[$], mig_pend[$];
  logic [DATA_W-1:0] exp_wdata[$], exp_rdata[$], src_q[$];
  int wr_cmd_cnt = 0, rd_cmd_cnt = 0, done_cnt = 0, en_only_cnt = 0, pop_cnt = 0;
  int stall_left = 0;
  logic [ADDR_W-1:0] stall_addr = '1;
  logic wr_acc, cmd_acc, dat_acc, pop_acc;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
    return {8{32'(a) ^ 32'hA5A5_0000}};
  endfunction

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic go(input bit w, input bit r, input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] n);
    start_wr = w; start_rd = r; base_addr = a; num_words = n;
    tick();
    start_wr = 1'b0; start_rd = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int s = done_cnt;
    int n = 0;
    while (done_cnt == s && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, (done_cnt != s), 1);
  endtask

  task automatic plan_write(input logic [ADDR_W-1:0] a, input int n, input logic [DATA_W-1:0] d0);
    for (int i = 0; i < n; i++) begin
      exp_waddr.push_back(a + ADDR_W'(i * 8));
      exp_wdata.push_back(d0 * (i + 1));
      src_q.push_back(d0 * (i + 1));
    end
  endtask

  task automatic plan_read(input logic [ADDR_W-1:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      exp_raddr.push_back(a + ADDR_W'(i * 8));
      exp_rdata.push_back(rd_pat(a + ADDR_W'(i * 8)));
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_en"}, app_bus.app_en, 0);
    check({tag, "_wren"}, app_bus.app_wdf_wren, 0);
    check({tag, "_addr"}, app_bus.app_addr, 0);
    check({tag, "_cmd"}, app_bus.app_cmd, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdv"}, rd_valid, 0);
    check({tag, "_wrr"}, wr_ready, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  // Behavioural MIG, write source and read sink: sample at negedge, drive just after posedge.
  initial begin
    app_bus.app_rdy = 1'b1;
    app_bus.app_wdf_rdy = 1'b1;
    app_bus.app_rd_data = '0;
    app_bus.app_rd_data_valid = 1'b0;
    forever begin
      @(negedge ui_clk);
      wr_acc  = wr_valid && wr_ready;
      cmd_acc = app_bus.app_en && app_bus.app_rdy;
      dat_acc = app_bus.app_wdf_wren && app_bus.app_wdf_rdy;
      pop_acc = rd_valid && rd_ready;
      if (!ui_clk_sync_rst) begin
        if (done) done_cnt++;
        check("wdf_end", app_bus.app_wdf_end, app_bus.app_wdf_wren);
        check("wdf_mask", app_bus.app_wdf_mask, 0);
        if (cmd_acc && app_bus.app_cmd == 3'b000) begin
          wr_cmd_cnt++;
          if (exp_waddr.size() > 0) check("wr_addr", app_bus.app_addr, exp_waddr.pop_front());
          else check("wr_unexpected", exp_waddr.size(), 1);
        end
        if (cmd_acc && app_bus.app_cmd == 3'b001) begin
          rd_cmd_cnt++;
          mig_pend.push_back(app_bus.app_addr);
          if (exp_raddr.size() > 0) check("rd_addr", app_bus.app_addr, exp_raddr.pop_front());
          else check("rd_unexpected", exp_raddr.size(), 1);
        end
        if (dat_acc) begin
          if (exp_wdata.size() > 0) check("wr_data", app_bus.app_wdf_data, exp_wdata.pop_front());
          else check("wdata_unexpected", exp_wdata.size(), 1);
        end
        if (app_bus.app_en && app_bus.app_cmd == 3'b000 && !app_bus.app_wdf_wren) en_only_cnt++;
        if (app_bus.app_en && !app_bus.app_rdy) check("stall_addr", app_bus.app_addr, stall_addr);
        if (pop_acc) begin
          pop_cnt++;
          if (exp_rdata.size() > 0) check("rd_data", rd_data, exp_rdata.pop_front());
          else check("rdata_unexpected", exp_rdata.size(), 1);
        end
      end
      @(posedge ui_clk);
      #1;
      if (wr_acc && src_q.size() > 0) void'(src_q.pop_front());
      wr_valid = (src_q.size() > 0);
      wr_data  = wr_valid ? src_q[0] : '0;
      if (mig_pend.size() > 0) begin
        app_bus.app_rd_data_valid = 1'b1;
        app_bus.app_rd_data = rd_pat(mig_pend.pop_front());
      end else begin
        app_bus.app_rd_data_valid = 1'b0;
      end
      if (stall_left > 0 && app_bus.app_en && app_bus.app_addr == stall_addr) begin
        app_bus.app_rdy = 1'b0;
        stall_left--;
      end else begin
        app_bus.app_rdy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr, base_rd, n;
    tick();
    tick();
    check_idle_zero("reset");
    check("reset_done", done, 0);
    ui_clk_sync_rst = 1'b0;
    init_calib_complete = 1'b1;
    tick();

    // Four-word write at full MIG readiness
    plan_write('0, 4, 256'd2);
    go(1, 0, '0, 4);
    wait_done("t1", 100);
    check("t1_wcmds", wr_cmd_cnt, 4);
    check("t1_busy", busy, 0);
    check("t1_wq", exp_waddr.size() + exp_wdata.size(), 0);

    // Same write with the command channel stalled on word 2
    en_only_cnt = 0;
    stall_addr = ADDR_W'(8);
    stall_left = 3;
    plan_write('0, 4, 256'd2);
    go(1, 0, '0, 4);
    wait_done("t2", 100);
    check("t2_wcmds", wr_cmd_cnt, 8);
    check("t2_en_only", en_only_cnt, 3);
    check("t2_wq", exp_waddr.size() + exp_wdata.size(), 0);
`ifdef DDR3_APP_SEQ_STALL_CNT_EN
    check("t2_stall_cnt", stall_cnt, 3);
`else
    check("t2_stall_cnt", stall_cnt, 0);
`endif

    // Credit-limited read with the sink blocked, then drained
    base_rd = rd_cmd_cnt;
    pop_cnt = 0;
    plan_read('0, 20);
    go(0, 1, '0, 20);
    for (int i = 0; i < 40; i++) tick();
    check("t3_issued_blocked", rd_cmd_cnt - base_rd, 8);
    check("t3_en_low", app_bus.app_en, 0);
    check("t3_rdv", rd_valid, 1);
    check("t3_busy", busy, 1);
    rd_ready = 1'b1;
    wait_done("t3", 400);
    check("t3_issued", rd_cmd_cnt - base_rd, 20);
    check("t3_popped", pop_cnt, 20);
    check("t3_rq", exp_raddr.size() + exp_rdata.size(), 0);

    // Both starts together: write wins
    base_wr = wr_cmd_cnt;
    base_rd = rd_cmd_cnt;
    plan_write(ADDR_W'(64), 1, 256'hABC);
    go(1, 1, ADDR_W'(64), 1);
    wait_done("t4", 50);
    check("t4_wcmds", wr_cmd_cnt - base_wr, 1);
    check("t4_rcmds", rd_cmd_cnt - base_rd, 0);

    // Zero-length burst finishes immediately without a command
    base_wr = wr_cmd_cnt;
    go(1, 0, ADDR_W'(16), 0);
    check("t4_n0_done", done, 1);
    check("t4_n0_busy", busy, 1);
    tick();
    check("t4_n0_done_pulse", done, 0);
    check("t4_n0_idle", busy, 0);
    check("t4_n0_cmds", wr_cmd_cnt - base_wr, 0);
    check("t4_n0_en", app_bus.app_en, 0);

    // Address wrap at the top of the space
    base_wr = wr_cmd_cnt;
    plan_write(ADDR_W'(29'h1FFF_FFF8), 2, 256'h11);
    go(1, 0, ADDR_W'(29'h1FFF_FFF8), 2);
    wait_done("t5", 50);
    check("t5_wcmds", wr_cmd_cnt - base_wr, 2);
    check("t5_wq", exp_waddr.size() + exp_wdata.size(), 0);

    // Starts are ignored until calibration completes
    init_calib_complete = 1'b0;
    n = done_cnt;
    go(1, 0, '0, 1);
    tick();
    tick();
    check("t5_calib_busy", busy, 0);
    check("t5_calib_done", done_cnt - n, 0);
    init_calib_complete = 1'b1;

    // Reset in the middle of a read burst
    rd_ready = 1'b0;
    base_rd = rd_cmd_cnt;
    plan_read(ADDR_W'(29'h100), 10);
    go(0, 1, ADDR_W'(29'h100), 10);
    n = 0;
    while (rd_cmd_cnt - base_rd < 3 && n < 50) begin
      tick();
      n++;
    end
    check("t6_three_reads", (rd_cmd_cnt - base_rd >= 3), 1);
    ui_clk_sync_rst = 1'b1;
    #1;
    check_idle_zero("t6_async");
    tick();
    tick();
    check_idle_zero("t6_held");
    ui_clk_sync_rst = 1'b0;
    exp_raddr.delete();
    exp_rdata.delete();
    for (int i = 0; i < 5; i++) tick();
    check_idle_zero("t6_after");
    check("t6_no_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
